// File: rtl/pty_frame_checker.sv
// Streaming even/odd parity checker with per-frame reports and a saturating lifetime error count.
// Optional sticky error flag (clr_sticky / sticky_err) is compiled in with `define PTY_STICKY_ERR_EN.
module pty_frame_checker #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8,
  localparam int ERR_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_par,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_words,
  output logic [CNT_W-1:0] total_err
`ifdef PTY_STICKY_ERR_EN
  ,
  input  logic             clr_sticky,
  output logic             sticky_err
`endif
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic               run_par_q, run_par_d;
  logic [ERR_W-1:0]   run_cnt_q, run_cnt_d;
  logic               frame_par_q, frame_par_d;
  logic               frame_err_q, frame_err_d;
  logic [ERR_W-1:0]   err_words_q, err_words_d;
  logic [CNT_W-1:0]   total_q, total_d;

  logic               transfer;
  logic               word_par;
  logic               mode_f;
  logic               word_fail;
  logic               last_word;
  logic [ERR_W-1:0]   run_cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  // Mode is captured with word 0; later words of the frame reuse the latched copy.
  always_comb begin
    transfer    = in_valid & in_ready;
    word_par    = ^in_data;
    mode_f      = (idx_q == '0) ? mode : mode_q;
    word_fail   = in_par != (word_par ^ mode_f);
    last_word   = (idx_q == LAST_IDX);
    run_cnt_inc = run_cnt_q + ERR_W'(word_fail);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (transfer && last_word)   state_d = REPORT;
      REPORT:  if (out_valid && out_ready)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == REPORT);
  end

  always_comb begin
    idx_d       = idx_q;
    mode_d      = mode_q;
    run_par_d   = run_par_q;
    run_cnt_d   = run_cnt_q;
    frame_par_d = frame_par_q;
    frame_err_d = frame_err_q;
    err_words_d = err_words_q;
    total_d     = total_q;
    if (transfer) begin
      total_d = sat_inc(total_q, word_fail);
      if (idx_q == '0) begin
        mode_d = mode;
      end
      if (last_word) begin
        frame_par_d = run_par_q ^ word_par;
        err_words_d = run_cnt_inc;
        frame_err_d = (run_cnt_inc != '0);
        idx_d       = '0;
        run_par_d   = 1'b0;
        run_cnt_d   = '0;
      end else begin
        idx_d     = idx_q + 1'b1;
        run_par_d = run_par_q ^ word_par;
        run_cnt_d = run_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      mode_q      <= 1'b0;
      run_par_q   <= 1'b0;
      run_cnt_q   <= '0;
      frame_par_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_words_q <= '0;
      total_q     <= '0;
    end else begin
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      run_par_q   <= run_par_d;
      run_cnt_q   <= run_cnt_d;
      frame_par_q <= frame_par_d;
      frame_err_q <= frame_err_d;
      err_words_q <= err_words_d;
      total_q     <= total_d;
    end
  end

  assign frame_par = frame_par_q;
  assign frame_err = frame_err_q;
  assign err_words = err_words_q;
  assign total_err = total_q;

`ifdef PTY_STICKY_ERR_EN
  logic sticky_q, sticky_d;

  // A failing transfer wins over a coincident clear.
  always_comb begin
    sticky_d = (sticky_q & ~clr_sticky) | (transfer & word_fail);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_err = sticky_q;
`endif

endmodule

// File: tb/tb_pty_frame_checker.sv
// Directed bench for pty_frame_checker: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_pty_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_par = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, frame_par, frame_err;
  logic [2:0] err_words;
  logic [7:0] total_err;

  logic       s_in_ready, s_out_valid, s_frame_par, s_frame_err;
  logic [2:0] s_err_words;
  logic [1:0] s_total_err;

`ifdef PTY_STICKY_ERR_EN
  logic clr_sticky = 1'b0;
  logic sticky_err, s_sticky_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pty_frame_checker #(.WIDTH(4), .FRAME_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid), .out_ready(out_ready),
    .frame_par(frame_par), .frame_err(frame_err), .err_words(err_words), .total_err(total_err)
`ifdef PTY_STICKY_ERR_EN
    , .clr_sticky(clr_sticky), .sticky_err(sticky_err)
`endif
  );

  pty_frame_checker #(.WIDTH(4), .FRAME_LEN(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(s_out_valid), .out_ready(out_ready),
    .frame_par(s_frame_par), .frame_err(s_frame_err), .err_words(s_err_words),
    .total_err(s_total_err)
`ifdef PTY_STICKY_ERR_EN
    , .clr_sticky(clr_sticky), .sticky_err(s_sticky_err)
`endif
  );

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [3:0] d, input logic p, input logic m);
    int n;
    @(negedge clk);
    mode = m; in_data = d; in_par = p; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL send_word_timeout in_ready=%0b want 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] words, input logic [3:0] pars, input logic [3:0] modes);
    for (int i = 0; i < 4; i++) send_word(words[4*i +: 4], pars[i], modes[i]);
  endtask

  task automatic ack_report();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (frame_par !== 1'b0) begin n_fail++; $display("FAIL reset_frame_par got=%0b exp=0", frame_par); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    n_cmp++; if (err_words !== 3'd0) begin n_fail++; $display("FAIL reset_err_words got=%0d exp=0", err_words); end
    n_cmp++; if (total_err !== 8'd0) begin n_fail++; $display("FAIL reset_total_err got=%0d exp=0", total_err); end
  endtask

  task automatic test_even();
    send_frame(16'hFBC8, 4'b0101, 4'b0000);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL even_out_valid got=%0b exp=1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL even_in_ready got=%0b exp=0", in_ready); end
    n_cmp++; if (frame_par !== 1'b0) begin n_fail++; $display("FAIL even_frame_par got=%0b exp=0", frame_par); end
    n_cmp++; if (err_words !== 3'd0) begin n_fail++; $display("FAIL even_err_words got=%0d exp=0", err_words); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL even_frame_err got=%0b exp=0", frame_err); end
    n_cmp++; if (total_err !== 8'd0) begin n_fail++; $display("FAIL even_total_err got=%0d exp=0", total_err); end
    ack_report();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL even_ready_after_ack got=%0b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL even_valid_after_ack got=%0b exp=0", out_valid); end
  endtask

  task automatic test_odd();
    send_frame(16'hFBC8, 4'b1010, 4'b1111);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL odd_clean_out_valid got=%0b exp=1", out_valid); end
    n_cmp++; if (err_words !== 3'd0) begin n_fail++; $display("FAIL odd_clean_err_words got=%0d exp=0", err_words); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL odd_clean_frame_err got=%0b exp=0", frame_err); end
    ack_report();
    send_frame(16'hFBC8, 4'b0101, 4'b1111);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL odd_bad_out_valid got=%0b exp=1", out_valid); end
    n_cmp++; if (err_words !== 3'd4) begin n_fail++; $display("FAIL odd_bad_err_words got=%0d exp=4", err_words); end
    n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL odd_bad_frame_err got=%0b exp=1", frame_err); end
    n_cmp++; if (frame_par !== 1'b0) begin n_fail++; $display("FAIL odd_bad_frame_par got=%0b exp=0", frame_par); end
    n_cmp++; if (total_err !== 8'd4) begin n_fail++; $display("FAIL odd_bad_total_err got=%0d exp=4", total_err); end
    n_cmp++; if (s_total_err !== 2'd3) begin n_fail++; $display("FAIL odd_bad_sat_total got=%0d exp=3", s_total_err); end
    ack_report();
  endtask

  task automatic test_backpressure();
    send_frame(16'h0001, 4'b1001, 4'b0000);
    mode = 1'b0; in_data = 4'd8; in_par = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%0b exp=1", i, out_valid); end
      n_cmp++; if ({frame_par, frame_err, err_words} !== 5'b11001) begin
        n_fail++; $display("FAIL bp_report[%0d] got=%b exp=11001", i, {frame_par, frame_err, err_words});
      end
    end
    n_cmp++; if (total_err !== 8'd5) begin n_fail++; $display("FAIL bp_total_err got=%0d exp=5", total_err); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_ack got=%0b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after_ack got=%0b exp=0", out_valid); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    send_word(4'd12, 1'b0, 1'b0);
    send_word(4'd11, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_early_report got=%0b exp=0", out_valid); end
    send_word(4'd15, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_out_valid got=%0b exp=1", out_valid); end
    n_cmp++; if ({frame_par, frame_err, err_words} !== 5'b00000) begin
      n_fail++; $display("FAIL bp_next_report got=%b exp=00000", {frame_par, frame_err, err_words});
    end
    ack_report();
  endtask

  task automatic test_mode_change();
    send_frame(16'hFBC8, 4'b0101, 4'b1110);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode_chg_out_valid got=%0b exp=1", out_valid); end
    n_cmp++; if (err_words !== 3'd0) begin n_fail++; $display("FAIL mode_chg_err_words got=%0d exp=0", err_words); end
    n_cmp++; if (total_err !== 8'd5) begin n_fail++; $display("FAIL mode_chg_total_err got=%0d exp=5", total_err); end
    ack_report();
  endtask

  task automatic test_saturation();
    do_reset();
    n_cmp++; if (s_total_err !== 2'd0) begin n_fail++; $display("FAIL sat_reset_total got=%0d exp=0", s_total_err); end
    send_frame(16'h8888, 4'b0000, 4'b0000);
    @(negedge clk);
    n_cmp++; if ({s_out_valid, s_frame_par, s_frame_err, s_err_words} !== 6'b101100) begin
      n_fail++; $display("FAIL sat_report got=%b exp=101100", {s_out_valid, s_frame_par, s_frame_err, s_err_words});
    end
    n_cmp++; if (s_total_err !== 2'd3) begin n_fail++; $display("FAIL sat_total_4 got=%0d exp=3", s_total_err); end
    ack_report();
    n_cmp++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_in_ready got=%0b exp=1", s_in_ready); end
    for (int i = 0; i < 3; i++) send_word(4'd8, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (s_total_err !== 2'd3) begin n_fail++; $display("FAIL sat_total_7 got=%0d exp=3", s_total_err); end
    n_cmp++; if (total_err !== 8'd7) begin n_fail++; $display("FAIL wide_total_7 got=%0d exp=7", total_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(4'd8, 1'b0, 1'b0);
    send_word(4'd8, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (total_err !== 8'd2) begin n_fail++; $display("FAIL mid_total_pre got=%0d exp=2", total_err); end
    do_reset();
    n_cmp++; if (total_err !== 8'd0) begin n_fail++; $display("FAIL mid_total_post got=%0d exp=0", total_err); end
    send_word(4'd1, 1'b1, 1'b0);
    send_word(4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_report got=%0b exp=0", out_valid); end
    send_word(4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_report3 got=%0b exp=0", out_valid); end
    send_word(4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if ({out_valid, frame_par, frame_err, err_words} !== 6'b110000) begin
      n_fail++; $display("FAIL mid_report got=%b exp=110000", {out_valid, frame_par, frame_err, err_words});
    end
    do_reset();
    n_cmp++; if ({in_ready, out_valid, frame_par, err_words} !== 6'b100000) begin
      n_fail++; $display("FAIL report_reset got=%b exp=100000", {in_ready, out_valid, frame_par, err_words});
    end
  endtask

`ifdef PTY_STICKY_ERR_EN
  task automatic test_sticky();
    do_reset();
    n_cmp++; if (sticky_err !== 1'b0) begin n_fail++; $display("FAIL sticky_reset got=%0b exp=0", sticky_err); end
    send_frame(16'hFBC8, 4'b0100, 4'b0000);
    @(negedge clk);
    n_cmp++; if (sticky_err !== 1'b1) begin n_fail++; $display("FAIL sticky_set got=%0b exp=1", sticky_err); end
    ack_report();
    send_frame(16'hFBC8, 4'b0101, 4'b0000);
    @(negedge clk);
    n_cmp++; if (sticky_err !== 1'b1) begin n_fail++; $display("FAIL sticky_hold got=%0b exp=1", sticky_err); end
    ack_report();
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    n_cmp++; if (sticky_err !== 1'b0) begin n_fail++; $display("FAIL sticky_clear got=%0b exp=0", sticky_err); end
    clr_sticky = 1'b1;
    send_word(4'd8, 1'b0, 1'b0);
    clr_sticky = 1'b0;
    n_cmp++; if (sticky_err !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins got=%0b exp=1", sticky_err); end
    send_word(4'd12, 1'b0, 1'b0);
    send_word(4'd11, 1'b1, 1'b0);
    send_word(4'd15, 1'b0, 1'b0);
    ack_report();
  endtask
`endif

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_backpressure();
    test_mode_change();
    test_saturation();
    test_reset_mid();
`ifdef PTY_STICKY_ERR_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pty_frame_checker.md
Name: pty_frame_checker

Overview:
- Parametrised, streaming even/odd parity checker; successor to the 4-bit combinational parity detector.
- Accepts WIDTH-bit words, each with a received parity bit, over a valid/ready handshake, and checks each word against the frame's selected mode.
- Groups FRAME_LEN words into a frame and returns one per-frame report over a second handshake: frame parity, errored-word count and error flag.
- Also keeps a saturating lifetime error counter. Sits between a link receiver and downstream frame consumers.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- FRAME_LEN, 4, words per frame (>=1).
- CNT_W, 8, width of lifetime error counter (>=1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = even parity, 1 = odd parity; sampled on first word of each frame.
- in_valid  input  1  input word valid.
- in_ready  output  1  checker can accept a word.
- in_data  input  WIDTH  data word.
- in_par  input  1  received parity bit for in_data.
- out_valid  output  1  frame report valid.
- out_ready  input  1  consumer accepts report.
- frame_par  output  1  XOR of all data bits of the frame.
- frame_err  output  1  1 if any word in the frame failed its check.
- err_words  output  $clog2(FRAME_LEN+1)  count of failing words in the frame.
- total_err  output  CNT_W  lifetime count of failing words, saturating.

Behaviour:
- Reset, when rst_n = 0 at a clock edge:
  - state = ACCUM, in_ready = 1, out_valid = 0.
  - frame_par, frame_err, err_words and total_err = 0; word index = 0; latched mode = 0.
- Word transfer = in_valid & in_ready on a clock edge.
- Per-word check:
  - p = ^in_data.
  - Expected bit = p ^ mode_f, where mode_f is the mode latched on word index 0.
  - The word fails if in_par != expected.
  - Mode changes mid-frame are ignored.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
    - Each transfer XORs p into the running parity, adds the fail bit to the running count, increments the word index, and increments total_err unless it is at all-ones (saturate).
    - On the transfer with index = FRAME_LEN-1: load frame_par, err_words and frame_err (= running count incl. this word != 0) into the output registers; clear the running accumulators and index; go to REPORT.
  - REPORT: in_ready = 0, out_valid = 1; report outputs held stable.
    - On out_valid & out_ready: go to ACCUM next cycle, out_valid = 0.
- Latency:
  - out_valid rises the cycle after the last word's transfer.
  - in_ready returns the cycle after the report handshake, giving 1 bubble cycle per frame.
- out_ready held high in ACCUM has no effect.
- in_valid in REPORT is not accepted; the word must be held by the source.
- FRAME_LEN = 1: every transfer produces a report.
- Reset mid-frame or mid-REPORT: partial frame discarded, pending report dropped, all state as at reset.
- Report outputs are valid only while out_valid = 1. They retain their last value otherwise.

Optional Feature:
- Macro PTY_STICKY_ERR_EN.
- Defined:
  - Adds input clr_sticky (1) and output sticky_err (1); sticky_err resets to 0.
  - sticky_err sets on any failing word transfer and stays set until clr_sticky = 1.
  - A simultaneous failing transfer and clr_sticky leaves sticky_err = 1 (set wins).
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
- Even, clean frame: WIDTH=4, FRAME_LEN=4, mode=0, words 8,12,11,15 with in_par 1,0,1,0 -> one report: frame_par=0, err_words=0, frame_err=0, total_err=0.
- Odd mode: mode=1, same words, in_par 0,1,0,1 -> err_words=0. Then repeat with in_par 1,0,1,0 -> err_words=4, frame_err=1, total_err=4.
- Backpressure: complete a frame, hold out_ready=0 for 5 cycles -> in_ready=0 and report stable for all 5. Raise out_ready -> in_ready=1 the next cycle. Word 4 presented during REPORT is accepted only afterwards.
- Mid-frame mode change: mode=0 on word 0, mode=1 on words 1-3, words 8,12,11,15, in_par 1,0,1,0 -> err_words=0.
- Saturation and reset: CNT_W=2, seven failing words -> total_err=3 (holds at 3). rst_n=0 after 2 words of a frame -> no report, next frame counted from word 0, total_err=0.
- PTY_STICKY_ERR_EN: one failing word -> sticky_err=1 through the next clean frame. clr_sticky pulse -> 0. Failing transfer coincident with clr_sticky -> stays 1.
